// File: rtl/sine_lut_nch.sv
// Time-multiplexed quarter-wave sine/cosine generator for N_CH phase channels.
// One shared two-read-port ROM; results are presented together with a valid pulse.
module sine_lut_nch #(
    parameter int    I_WIDTH   = 13,
    parameter int    O_WIDTH   = 12,
    parameter int    N_CH      = 4,
    parameter string LOAD_PATH = ""
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_en,
    input  logic                    i_start,
    input  logic [N_CH*I_WIDTH-1:0] i_phase,
    output logic [N_CH*O_WIDTH-1:0] o_sin,
    output logic [N_CH*O_WIDTH-1:0] o_cos,
    output logic                    o_valid,
    output logic                    o_busy
);

    localparam int  AW    = I_WIDTH - 2;
    localparam int  DEPTH = 1 << AW;
    localparam int  CW    = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam real AMP   = real'((1 << (O_WIDTH - 1)) - 1);
    localparam real PI    = 3.14159265358979323846;
    localparam real FULL  = real'(1 << I_WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    // Sample at the bin centre so mirrored addresses land on identical values
    function automatic logic [O_WIDTH-1:0] f_rom(input int j);
        return O_WIDTH'($rtoi(AMP * $sin(2.0 * PI * (real'(j) + 0.5) / FULL) + 0.5));
    endfunction

    logic [O_WIDTH-1:0] w_rom [DEPTH];

    for (genvar j = 0; j < DEPTH; j++) begin : g_e
        localparam logic [O_WIDTH-1:0] C_VAL = f_rom(j);
        assign w_rom[j] = C_VAL;
    end

    state_t                  r_state;
    state_t                  w_next;
    logic [CW-1:0]           r_ch;
    logic [N_CH*I_WIDTH-1:0] r_phase;

    logic [I_WIDTH-1:0] w_ph [N_CH];
    logic [I_WIDTH-1:0] w_ps;
    logic [I_WIDTH-1:0] w_pc;

    logic               r_a_vld;
    logic [AW-1:0]      r_a_adr_s;
    logic [AW-1:0]      r_a_adr_c;
    logic               r_a_neg_s;
    logic               r_a_neg_c;
    logic [CW-1:0]      r_a_ch;

    logic               r_b_vld;
    logic [O_WIDTH-1:0] r_b_dat_s;
    logic [O_WIDTH-1:0] r_b_dat_c;
    logic               r_b_neg_s;
    logic               r_b_neg_c;
    logic [CW-1:0]      r_b_ch;

    logic [O_WIDTH-1:0] r_bs [N_CH];
    logic [O_WIDTH-1:0] r_bc [N_CH];

    logic [N_CH*O_WIDTH-1:0] r_sin;
    logic [N_CH*O_WIDTH-1:0] r_cos;
    logic                    r_valid;

    for (genvar k = 0; k < N_CH; k++) begin : g_ph
        assign w_ph[k] = r_phase[k*I_WIDTH +: I_WIDTH];
    end

    assign w_ps = w_ph[r_ch];
    assign w_pc = w_ps + I_WIDTH'(DEPTH);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else if (i_en) begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (i_start) w_next = S_RUN;
            S_RUN:   if (r_ch == CW'(N_CH - 1)) w_next = S_DRAIN;
            S_DRAIN: if (!r_a_vld) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ch    <= '0;
            r_phase <= '0;
        end else if (i_en) begin
            if (r_state == S_IDLE && i_start) begin
                r_phase <= i_phase;
                r_ch    <= '0;
            end else if (r_state == S_RUN) begin
                r_ch    <= r_ch + CW'(1);
            end
        end
    end

    // Three-stage lookup: address/quadrant, ROM read, sign apply into bank
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_a_vld   <= 1'b0;
            r_a_adr_s <= '0;
            r_a_adr_c <= '0;
            r_a_neg_s <= 1'b0;
            r_a_neg_c <= 1'b0;
            r_a_ch    <= '0;
            r_b_vld   <= 1'b0;
            r_b_dat_s <= '0;
            r_b_dat_c <= '0;
            r_b_neg_s <= 1'b0;
            r_b_neg_c <= 1'b0;
            r_b_ch    <= '0;
            for (int k = 0; k < N_CH; k++) begin
                r_bs[k] <= '0;
                r_bc[k] <= '0;
            end
        end else if (i_en) begin
            r_a_vld   <= (r_state == S_RUN);
            r_a_adr_s <= w_ps[I_WIDTH-2] ? ~w_ps[AW-1:0] : w_ps[AW-1:0];
            r_a_adr_c <= w_pc[I_WIDTH-2] ? ~w_pc[AW-1:0] : w_pc[AW-1:0];
            r_a_neg_s <= w_ps[I_WIDTH-1];
            r_a_neg_c <= w_pc[I_WIDTH-1];
            r_a_ch    <= r_ch;
            r_b_vld   <= r_a_vld;
            r_b_dat_s <= w_rom[r_a_adr_s];
            r_b_dat_c <= w_rom[r_a_adr_c];
            r_b_neg_s <= r_a_neg_s;
            r_b_neg_c <= r_a_neg_c;
            r_b_ch    <= r_a_ch;
            if (r_b_vld) begin
                r_bs[r_b_ch] <= r_b_neg_s ? -r_b_dat_s : r_b_dat_s;
                r_bc[r_b_ch] <= r_b_neg_c ? -r_b_dat_c : r_b_dat_c;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sin   <= '0;
            r_cos   <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= i_en && (r_state == S_DONE);
            if (i_en && r_state == S_DONE) begin
                for (int k = 0; k < N_CH; k++) begin
                    r_sin[k*O_WIDTH +: O_WIDTH] <= r_bs[k];
                    r_cos[k*O_WIDTH +: O_WIDTH] <= r_bc[k];
                end
            end
        end
    end

    assign o_sin   = r_sin;
    assign o_cos   = r_cos;
    assign o_valid = r_valid;
    assign o_busy  = (r_state != S_IDLE);

endmodule
